// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit control path.
package uart_ctrl_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int HOLD_TIMEOUT_DEFAULT = 50000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// the start pointer, wrapping around the request vector.
module rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic               found,
  output logic [IW-1:0]      index
);

  int pos;

  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(start) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, with
// message locking and a hold timeout so a stalled owner cannot block the line.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT,
  localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           tx_dv,
  output logic [UART_BYTE_W-1:0]         tx_byte,
  input  logic                           tx_active,
  input  logic                           tx_done,
  output logic                           grant_valid,
  output logic [GW-1:0]                  grant_id
);

  localparam int            CW        = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_ID   = GW'(NUM_REQ - 1);

  arb_state_t   state;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] hold_cnt;
  logic          last_q;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          issue_en;
  logic [GW-1:0] issue_id;
  logic [NUM_REQ-1:0] issue_onehot;
  logic [GW-1:0] next_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .start (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // While locked only the current owner may issue; the tx_active gate in IDLE
  // covers a byte still draining from uart_tx after a reset.
  always_comb begin
    issue_id = (state == HOLD) ? grant_id : pick_idx;
    issue_en = 1'b0;
    if (state == IDLE)      issue_en = pick_found && !tx_active;
    else if (state == HOLD) issue_en = req[issue_id];
    issue_onehot           = '0;
    issue_onehot[issue_id] = 1'b1;
    next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      last_q      <= 1'b0;
      req_ack     <= '0;
      tx_dv       <= 1'b0;
      tx_byte     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      req_ack <= '0;
      tx_dv   <= 1'b0;
      if (issue_en) begin
        tx_byte     <= req_data[issue_id*UART_BYTE_W +: UART_BYTE_W];
        tx_dv       <= 1'b1;
        req_ack     <= issue_onehot;
        grant_id    <= issue_id;
        grant_valid <= 1'b1;
        last_q      <= req_last[issue_id];
        state       <= WAIT;
      end else begin
        case (state)
          WAIT: begin
            if (tx_done) begin
              if (last_q) begin
                grant_valid <= 1'b0;
                rr_ptr      <= next_ptr;
                state       <= IDLE;
              end else begin
                hold_cnt <= '0;
                state    <= HOLD;
              end
            end
          end
          HOLD: begin
            if (hold_cnt >= HOLD_LAST) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_ptr;
              state       <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: small uart_tx and requester models
// driven one negedge at a time, with hand-computed expected traces.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_last, req_ack;
  logic [31:0] req_data;
  logic        tx_dv, tx_active, tx_done, grant_valid;
  logic [7:0]  tx_byte;
  logic [1:0]  grant_id;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic       busy;
  int         done_at;
  int         uart_len;
  logic [7:0] byte_mem [4][8];
  logic       last_mem [4][8];
  int         head [4];
  int         tail [4];

  logic [7:0] log_byte[$];
  int         log_id[$];
  int         log_cyc[$];
  logic [3:0] log_ack[$];

  uart_tx_arbiter #(.NUM_REQ(4), .HOLD_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_dv       (tx_dv),
    .tx_byte     (tx_byte),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lb(input int k);
    return (k < log_byte.size()) ? log_byte[k] : 8'hxx;
  endfunction
  function automatic int li(input int k);
    return (k < log_id.size()) ? log_id[k] : -1;
  endfunction
  function automatic int lc(input int k);
    return (k < log_cyc.size()) ? log_cyc[k] : -1;
  endfunction
  function automatic logic [3:0] la(input int k);
    return (k < log_ack.size()) ? log_ack[k] : 4'hx;
  endfunction

  task automatic push(input int i, input logic [7:0] b, input logic l);
    byte_mem[i][tail[i]] = b;
    last_mem[i][tail[i]] = l;
    tail[i]++;
  endtask

  // One cycle: observe outputs at negedge, then update uart and requester models.
  task automatic tick();
    @(negedge clk);
    cyc++;
    tx_done = 1'b0;
    if (busy && cyc == done_at) begin
      tx_done   = 1'b1;
      tx_active = 1'b0;
      busy      = 1'b0;
    end
    if (tx_dv) begin
      log_byte.push_back(tx_byte);
      log_id.push_back(int'(grant_id));
      log_cyc.push_back(cyc);
      log_ack.push_back(req_ack);
      busy      = 1'b1;
      tx_active = 1'b1;
      done_at   = cyc + uart_len;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i] && head[i] < tail[i]) head[i]++;
      if (head[i] < tail[i]) begin
        req[i]            = 1'b1;
        req_data[8*i +: 8] = byte_mem[i][head[i]];
        req_last[i]       = last_mem[i][head[i]];
      end else begin
        req[i]      = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    busy      = 1'b0;
    req       = '0;
    req_last  = '0;
    req_data  = '0;
    uart_len  = 4;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    tick();
    tick();
    rst = 1'b1;
    log_byte.delete();
    log_id.delete();
    log_cyc.delete();
    log_ack.delete();
  endtask

  task automatic wait_log(input int n, input string what);
    int k;
    k = 0;
    while (log_byte.size() < n && k < 500) begin
      tick();
      k++;
    end
    if (log_byte.size() < n) begin
      checks++;
      $display("[TB] FAIL %s timeout: got %0d issues, expected %0d", what, log_byte.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_dv !== 1'b0) $display("[TB] FAIL reset tx_dv: got %b expected 0", tx_dv); else passed++;
    checks++; if (req_ack !== 4'b0) $display("[TB] FAIL reset req_ack: got %b expected 0000", req_ack); else passed++;
    checks++; if (tx_byte !== 8'h00) $display("[TB] FAIL reset tx_byte: got %h expected 00", tx_byte); else passed++;
    checks++; if (grant_valid !== 1'b0) $display("[TB] FAIL reset grant_valid: got %b expected 0", grant_valid); else passed++;
    checks++; if (grant_id !== 2'd0) $display("[TB] FAIL reset grant_id: got %0d expected 0", grant_id); else passed++;
  endtask

  task automatic test_single();
    int t0;
    do_reset();
    uart_len = 20;
    push(0, 8'h41, 1'b1);
    tick();
    t0 = cyc;
    tick();
    checks++; if (tx_dv !== 1'b1) $display("[TB] FAIL single tx_dv: got %b expected 1", tx_dv); else passed++;
    checks++; if (req_ack !== 4'b0001) $display("[TB] FAIL single req_ack: got %b expected 0001", req_ack); else passed++;
    checks++; if (tx_byte !== 8'h41) $display("[TB] FAIL single tx_byte: got %h expected 41", tx_byte); else passed++;
    checks++; if (grant_valid !== 1'b1) $display("[TB] FAIL single grant_valid: got %b expected 1", grant_valid); else passed++;
    checks++; if (grant_id !== 2'd0) $display("[TB] FAIL single grant_id: got %0d expected 0", grant_id); else passed++;
    tick();
    checks++; if (tx_dv !== 1'b0) $display("[TB] FAIL single tx_dv pulse: got %b expected 0", tx_dv); else passed++;
    checks++; if (req_ack !== 4'b0000) $display("[TB] FAIL single req_ack pulse: got %b expected 0000", req_ack); else passed++;
    checks++; if (tx_byte !== 8'h41) $display("[TB] FAIL single tx_byte hold: got %h expected 41", tx_byte); else passed++;
    while (cyc < t0 + 21) tick();
    checks++; if (grant_valid !== 1'b1) $display("[TB] FAIL single grant before done: got %b expected 1", grant_valid); else passed++;
    tick();
    checks++; if (grant_valid !== 1'b0) $display("[TB] FAIL single grant release: got %b expected 0", grant_valid); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b [5];
    int         exp_i [5];
    exp_b = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
    exp_i = '{0, 1, 2, 3, 0};
    do_reset();
    push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1);
    push(2, 8'hC0, 1'b1); push(2, 8'hC1, 1'b1);
    push(3, 8'hD0, 1'b1); push(3, 8'hD1, 1'b1);
    wait_log(5, "rr");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (li(k) !== exp_i[k]) $display("[TB] FAIL rr grant %0d: got %0d expected %0d", k, li(k), exp_i[k]); else passed++;
      checks++;
      if (lb(k) !== exp_b[k]) $display("[TB] FAIL rr byte %0d: got %h expected %h", k, lb(k), exp_b[k]); else passed++;
    end
  endtask

  task automatic test_message_lock();
    logic [7:0] exp_b [4];
    int         exp_i [4];
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h55};
    exp_i = '{2, 2, 2, 0};
    do_reset();
    push(2, 8'h10, 1'b0); push(2, 8'h11, 1'b0); push(2, 8'h12, 1'b1);
    tick();
    push(0, 8'h55, 1'b1);
    wait_log(4, "msg");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (li(k) !== exp_i[k]) $display("[TB] FAIL msg grant %0d: got %0d expected %0d", k, li(k), exp_i[k]); else passed++;
      checks++;
      if (lb(k) !== exp_b[k]) $display("[TB] FAIL msg byte %0d: got %h expected %h", k, lb(k), exp_b[k]); else passed++;
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (lc(k) - lc(k-1) !== 6) $display("[TB] FAIL msg reissue gap %0d: got %0d expected 6", k, lc(k) - lc(k-1)); else passed++;
    end
  endtask

  task automatic test_hold_timeout();
    int d;
    do_reset();
    push(1, 8'h21, 1'b0);
    push(3, 8'h33, 1'b1);
    wait_log(1, "timeout first");
    d = cyc;
    while (cyc < d + 12) tick();
    checks++; if (grant_valid !== 1'b1) $display("[TB] FAIL timeout grant held: got %b expected 1", grant_valid); else passed++;
    checks++; if (log_byte.size() !== 1) $display("[TB] FAIL timeout issues in hold: got %0d expected 1", log_byte.size()); else passed++;
    tick();
    checks++; if (grant_valid !== 1'b0) $display("[TB] FAIL timeout release: got %b expected 0", grant_valid); else passed++;
    tick();
    checks++; if (lc(1) !== d + 14) $display("[TB] FAIL timeout next issue cycle: got %0d expected %0d", lc(1), d + 14); else passed++;
    checks++; if (lb(1) !== 8'h33) $display("[TB] FAIL timeout next byte: got %h expected 33", lb(1)); else passed++;
    checks++; if (li(1) !== 3) $display("[TB] FAIL timeout next grant: got %0d expected 3", li(1)); else passed++;
  endtask

  task automatic test_reset_mid();
    int r;
    do_reset();
    uart_len = 100;
    push(2, 8'h77, 1'b1);
    wait_log(1, "rstmid first");
    tick();
    tick();
    push(1, 8'h88, 1'b1);
    rst = 1'b0;
    tick();
    r = cyc;
    done_at = r + 30;
    rst = 1'b1;
    checks++; if (grant_valid !== 1'b0) $display("[TB] FAIL rstmid grant_valid: got %b expected 0", grant_valid); else passed++;
    checks++; if (grant_id !== 2'd0) $display("[TB] FAIL rstmid grant_id: got %0d expected 0", grant_id); else passed++;
    checks++; if (tx_byte !== 8'h00) $display("[TB] FAIL rstmid tx_byte: got %h expected 00", tx_byte); else passed++;
    checks++; if (tx_dv !== 1'b0) $display("[TB] FAIL rstmid tx_dv: got %b expected 0", tx_dv); else passed++;
    checks++; if (req_ack !== 4'b0) $display("[TB] FAIL rstmid req_ack: got %b expected 0000", req_ack); else passed++;
    while (cyc < r + 31) tick();
    checks++; if (lc(1) !== r + 31) $display("[TB] FAIL rstmid gated issue cycle: got %0d expected %0d", lc(1), r + 31); else passed++;
    checks++; if (lb(1) !== 8'h88) $display("[TB] FAIL rstmid byte: got %h expected 88", lb(1)); else passed++;
    checks++; if (la(1) !== 4'b0010) $display("[TB] FAIL rstmid ack: got %b expected 0010", la(1)); else passed++;
  endtask

  task automatic test_idle_done();
    do_reset();
    tick();
    tx_done = 1'b1;
    tick();
    checks++; if (tx_dv !== 1'b0) $display("[TB] FAIL idle done tx_dv: got %b expected 0", tx_dv); else passed++;
    checks++; if (grant_valid !== 1'b0) $display("[TB] FAIL idle done grant_valid: got %b expected 0", grant_valid); else passed++;
    push(2, 8'h5A, 1'b1);
    tick();
    tick();
    checks++; if (tx_dv !== 1'b1) $display("[TB] FAIL idle done later issue: got %b expected 1", tx_dv); else passed++;
    checks++; if (grant_id !== 2'd2) $display("[TB] FAIL idle done grant_id: got %0d expected 2", grant_id); else passed++;
    checks++; if (req_ack !== 4'b0100) $display("[TB] FAIL idle done req_ack: got %b expected 0100", req_ack); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_message_lock();
    test_hold_timeout();
    test_reset_mid();
    test_idle_done();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `NUM_REQ` byte producers. It sits between the producers and the UART wrapper's `iTx_DV` / `i_Tx_Byte` / `o_Tx_Active` / `o_Tx_Done` pins. It issues one byte at a time and can lock the grant to one requester for a multi-byte message, so messages never interleave on the serial line. A hold timeout ensures a stalled requester cannot block the line.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 1..16.
- `HOLD_TIMEOUT`, 50000: clk cycles a locked grant waits for the owner's next byte (1 ms at 50 MHz), ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester "byte available", level.
- `req_last`  in  NUM_REQ  the presented byte ends the message; sampled with `req`.
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- `req_ack`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- `tx_dv`  out  1  to `iTx_DV`, one-cycle pulse.
- `tx_byte`  out  8  to `i_Tx_Byte`, held stable until the next issue.
- `tx_active`  in  1  from `o_Tx_Active`.
- `tx_done`  in  1  from `o_Tx_Done`, one-cycle pulse.
- `grant_valid`  out  1  a requester currently owns the line.
- `grant_id`  out  max(1,$clog2(NUM_REQ))  owner index, valid when `grant_valid`.

## Operation
- States: IDLE, WAIT, HOLD.
- **IDLE** (nothing granted):
  - If any `req` is high and `tx_active` = 0, pick winner i by round-robin starting at `rr_ptr`.
  - On that edge: `tx_byte` ← `req_data[i]`, `tx_dv` ← 1, `req_ack[i]` ← 1, `grant_id` ← i, `grant_valid` ← 1, `last_q` ← `req_last[i]`, go to WAIT.
- **WAIT**: wait for `tx_done`.
  - If `last_q` = 1: `grant_valid` ← 0, `rr_ptr` ← (i+1) mod NUM_REQ, go to IDLE.
  - Otherwise: clear the hold counter and go to HOLD.
- **HOLD**: only requester i is eligible; other `req` lines are ignored.
  - If `req[i]` = 1: issue exactly as in IDLE, with the same i, and go to WAIT.
  - Else the counter increments. When it reaches `HOLD_TIMEOUT - 1`: release the grant as in the `last_q` case and go to IDLE.
- Round-robin pointer `rr_ptr` resets to 0. It advances only on grant release, never per byte.
- A requester keeps `req`/`req_data`/`req_last` stable until it sees `req_ack`.
  - The cycle after `req_ack` it either drops `req` or presents its next byte.
  - A request withdrawn before ack is simply not served.
- `tx_dv` and `req_ack` are never high for more than one cycle, and never while in WAIT.
- A `tx_done` pulse outside WAIT is ignored.
- With `NUM_REQ` = 1, the round-robin degenerates to a fixed grant, and timeout behaviour is unchanged.

## Timing
- Reset values: `req_ack` = 0, `tx_dv` = 0, `tx_byte` = 8'h00, `grant_valid` = 0, `grant_id` = 0. Internal: state = IDLE, `rr_ptr` = 0, hold counter = 0.
- Issue latency: a `req` sampled high at edge k in IDLE or HOLD gives `tx_dv` and `req_ack` high during cycle k..k+1.
- Re-issue: the earliest next `tx_dv` is 1 cycle after the `tx_done` edge in HOLD. From IDLE it is 1 cycle after `tx_done`, provided `tx_active` = 0.
- Reset mid-operation (`rst` low at any edge) returns everything to reset values. A byte already in `uart_tx` finishes on its own. The IDLE `tx_active` gate prevents a new `tx_dv` until that byte completes.
- Timeout: the release edge is the `HOLD_TIMEOUT`-th cycle in HOLD with `req[i]` low.
  - If `req[i]` rises on that same edge, the issue wins and there is no release.
- Hold counter width is $clog2(HOLD_TIMEOUT+1) and the counter saturates (no wrap).

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum (IDLE, WAIT, HOLD);
  - `UART_BYTE_W` = 8;
  - the default `HOLD_TIMEOUT`.
- Sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: request vector and start pointer.
  - Outputs: `found` and `index`.
  - Parameterised by `NUM_REQ`.
- All outputs are registered in the top module.

## Test plan
- Reset, then `req` = 4'b0001, `req_last` = 1, data 8'h41 → `tx_dv` and `req_ack[0]` pulse the next cycle with `tx_byte` = 8'h41. Bench `tx_done` arrives after 20 cycles → `grant_valid` falls 1 cycle later.
- `req` = 4'b1111, all `req_last` = 1, held continuously → grant order 0, 1, 2, 3, 0, each served once per rotation.
- Requester 2 sends 3 bytes 8'h10/8'h11/8'h12, `req_last` on the third, while requester 0 holds `req` high → line carries 10, 11, 12 contiguously, then requester 0 is served.
- `HOLD_TIMEOUT` = 8, requester 1 sends one byte with `req_last` = 0 then drops `req` → release exactly 8 cycles into HOLD, and requester 3's pending `req` is served next.
- Assert `rst` low during WAIT while the bench keeps `tx_active` high for 30 more cycles → outputs take reset values, and no `tx_dv` occurs until `tx_active` falls.
- `tx_done` injected in IDLE with no request → no state change, no `tx_dv`.
